mips_main_control: RTL

Multicycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode. Drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU control decoder. Memory states stretch with a ready handshake; undefined opcodes are flagged and skipped.

---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/mips_ctrl_decode.sv | 66 ++++++
 rtl/mips_main_control.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes,
// ALUOp codes used by the ALU control decoder, and the control vector layout.
package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RCOMP   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_RST     = 4'd15;

  typedef enum logic [3:0] {
    ST_FETCH   = S_FETCH,
    ST_DECODE  = S_DECODE,
    ST_MEMADDR = S_MEMADDR,
    ST_MEMRD   = S_MEMRD,
    ST_MEMWB   = S_MEMWB,
    ST_MEMWR   = S_MEMWR,
    ST_EXEC    = S_EXEC,
    ST_RCOMP   = S_RCOMP,
    ST_BRANCH  = S_BRANCH,
    ST_JUMP    = S_JUMP,
    ST_RST     = S_RST
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Opcodes the sequencer knows; anything else is flagged in DECODE
  localparam int NUM_LEGAL_OPS = 5;
  localparam logic [NUM_LEGAL_OPS*6-1:0] LEGAL_OPS = {OP_J, OP_BEQ, OP_SW, OP_LW, OP_RTYPE};

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the current control state into the datapath control
// vector; only the FETCH strobes depend on mem_ready.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        // Latch IR and advance PC only on the cycle the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = ALUB_IMM_SL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RCOMP: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: state register, opcode-driven sequencing and
// the illegal-opcode flag; control outputs come from mips_ctrl_decode.
module mips_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;

  logic [NUM_LEGAL_OPS-1:0] op_hit;
  logic                     op_legal;

  for (genvar gi = 0; gi < NUM_LEGAL_OPS; gi++) begin : g_legal
    assign op_hit[gi] = (Opcode == LEGAL_OPS[gi*6 +: 6]);
  end
  assign op_legal = |op_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RST;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RST:   state_next = ST_FETCH;
      ST_FETCH: if (MemReady) state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_mem_op(Opcode)) state_next = ST_MEMADDR;
        else begin
          case (Opcode)
            OP_RTYPE: state_next = ST_EXEC;
            OP_BEQ:   state_next = ST_BRANCH;
            OP_J:     state_next = ST_JUMP;
            default:  state_next = ST_FETCH;
          endcase
        end
      end
      ST_MEMADDR: begin
        // Opcode is re-sampled here to pick the read or write leg
        case (Opcode)
          OP_LW:   state_next = ST_MEMRD;
          OP_SW:   state_next = ST_MEMWR;
          default: state_next = ST_FETCH;
        endcase
      end
      ST_MEMRD:  if (MemReady) state_next = ST_MEMWB;
      ST_MEMWB:  state_next = ST_FETCH;
      ST_MEMWR:  if (MemReady) state_next = ST_FETCH;
      ST_EXEC:   state_next = ST_RCOMP;
      ST_RCOMP:  state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_JUMP:   state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state     (state_reg),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  // Write strobes are also gated by rst_n so a reset cuts them in the same cycle
  assign PCWrite     = ctrl.pc_write      & rst_n;
  assign PCWriteCond = ctrl.pc_write_cond & rst_n;
  assign MemWrite    = ctrl.mem_write     & rst_n;
  assign RegWrite    = ctrl.reg_write     & rst_n;
  assign IRWrite     = ctrl.ir_write      & rst_n;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;

  assign IllegalOp   = (state_reg == ST_DECODE) && !op_legal;
  assign State       = state_reg;

endmodule
